// File: rtl/spu_issue_pkg.sv
// Shared types and constants for the SPU dual-issue stage.
// Contents:
//   dec_inst_t    - decoded instruction as presented by decode
//   slot_t        - per-slot payload driven to reg_fetch (without pc)
//   issue_state_t - holding state of the issue stage
//   NOP_OPCODE_E / LNOP_OPCODE_O - filler opcodes for idle slots
//   helper functions to build slot payloads and detect source hits
package spu_issue_pkg;

    localparam int REG_AW = 7;

    localparam logic [0:10] NOP_OPCODE_E  = 11'b01000000001;
    localparam logic [0:10] LNOP_OPCODE_O = 11'b00000000001;

    typedef struct packed {
        logic [0:10] op;
        logic        pipe;      // 0 = even pipe, 1 = odd pipe
        logic [0:6]  rt;
        logic [0:6]  ra;
        logic [0:6]  rb;
        logic [0:6]  rc;
        logic        use_ra;
        logic        use_rb;
        logic        use_rc;
        logic        wr_rt;
        logic [0:2]  lat;
        logic [0:17] imm;
        logic [0:14] pc;
    } dec_inst_t;

    typedef struct packed {
        logic [0:10] op;
        logic [0:6]  ra;
        logic [0:6]  rb;
        logic [0:6]  rc;
        logic [0:6]  rt;
        logic [0:17] imm;
    } slot_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HALF  = 2'd2
    } issue_state_t;

    // Payload of an idle slot: filler opcode, every other field zero.
    function automatic slot_t nop_slot(input logic [0:10] op);
        slot_t s;
        s     = '0;
        s.op  = op;
        return s;
    endfunction

    // Payload of an issuing instruction.
    function automatic slot_t to_slot(input dec_inst_t i);
        slot_t s;
        s.op  = i.op;
        s.ra  = i.ra;
        s.rb  = i.rb;
        s.rc  = i.rc;
        s.rt  = i.rt;
        s.imm = i.imm;
        return s;
    endfunction

    // True when instruction c actually reads register r through any source.
    function automatic logic src_hits(input dec_inst_t c, input logic [0:6] r);
        return (c.use_ra && (c.ra == r)) ||
               (c.use_rb && (c.rb == r)) ||
               (c.use_rc && (c.rc == r));
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register countdown scoreboard for the issue stage.
// Each entry holds the remaining cycles until its pending result is usable;
// non-zero entries count down by one per cycle, a set overrides the count.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (clears all entries)
//   rd_addr/rd_use  - six source read ports (address + "source is used")
//   rd_rdy          - per port: source unused or its entry is zero
//   set_en/addr/lat - two set ports (one per issuing instruction)
module issue_scoreboard
    import spu_issue_pkg::*;
#(
    parameter int NREG = 128,
    parameter int LATW = 3,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0][AW-1:0]   rd_addr,
    input  logic [5:0]           rd_use,
    output logic [5:0]           rd_rdy,
    input  logic [1:0]           set_en,
    input  logic [1:0][AW-1:0]   set_addr,
    input  logic [1:0][LATW-1:0] set_lat
);

    logic [LATW-1:0] sb_q [NREG];
    logic [LATW-1:0] sb_d [NREG];

    // Source readiness lookups.
    always_comb begin
        for (int p = 0; p < 6; p++) begin
            rd_rdy[p] = !rd_use[p] || (sb_q[rd_addr[p]] == '0);
        end
    end

    // Next counter values: a set wins over the countdown.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if (set_en[0] && (set_addr[0] == AW'(i))) begin
                sb_d[i] = set_lat[0];
            end else if (set_en[1] && (set_addr[1] == AW'(i))) begin
                sb_d[i] = set_lat[1];
            end else if (sb_q[i] != '0) begin
                sb_d[i] = sb_q[i] - LATW'(1);
            end else begin
                sb_d[i] = '0;
            end
        end
    end

    // Counter storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: rtl/dual_issue.sv
// SPU dual-issue stage between decode and reg_fetch.
// Accepts an in-order instruction pair (A older, B younger), steers each to
// the even or odd slot by its pipe bit, and holds back issue on RAW
// (scoreboard), intra-pair and structural hazards. Idle slots carry nop/lnop.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b - decode handshake (in_ready is combinational)
//   flush                  - taken branch from odd pipe; discards held pair
//   op_code_e/o, pres_addr_e1..3/o1..3, pres_dest_e/o, imm_e/o, pc_o
//                          - registered reg_fetch inputs for each slot
//   stall                  - registered: a held instruction could not issue
module dual_issue
    import spu_issue_pkg::*;
#(
    parameter int NREG = 128,
    parameter int LATW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  dec_inst_t   in_a,
    input  dec_inst_t   in_b,
    input  logic        flush,
    output logic [0:10] op_code_e,
    output logic [0:10] op_code_o,
    output logic [0:6]  pres_addr_e1,
    output logic [0:6]  pres_addr_e2,
    output logic [0:6]  pres_addr_e3,
    output logic [0:6]  pres_addr_o1,
    output logic [0:6]  pres_addr_o2,
    output logic [0:6]  pres_addr_o3,
    output logic [0:6]  pres_dest_e,
    output logic [0:6]  pres_dest_o,
    output logic [0:17] imm_e,
    output logic [0:17] imm_o,
    output logic [0:14] pc_o,
    output logic        stall
);

    issue_state_t state_q, state_d;
    dec_inst_t    a_q, a_d, b_q, b_d;
    slot_t        slot_e_q, slot_e_d, slot_o_q, slot_o_d;
    logic [0:14]  pc_o_q, pc_o_d;
    logic         stall_q, stall_d;

    logic [5:0][REG_AW-1:0] rd_addr_s;
    logic [5:0]             rd_use_s;
    logic [5:0]             rd_rdy_s;
    logic [1:0]             set_en_s;
    logic [1:0][REG_AW-1:0] set_addr_s;
    logic [1:0][LATW-1:0]   set_lat_s;

    logic a_rdy_s, b_rdy_s, pair_ok_s;
    logic a_iss_s, b_iss_s, drain_s, accept_s;

    issue_scoreboard #(
        .NREG (NREG),
        .LATW (LATW),
        .AW   (REG_AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr_s),
        .rd_use   (rd_use_s),
        .rd_rdy   (rd_rdy_s),
        .set_en   (set_en_s),
        .set_addr (set_addr_s),
        .set_lat  (set_lat_s)
    );

    // Scoreboard read ports: 0..2 are A's sources, 3..5 are B's sources.
    always_comb begin
        rd_addr_s[0] = a_q.ra;  rd_use_s[0] = a_q.use_ra;
        rd_addr_s[1] = a_q.rb;  rd_use_s[1] = a_q.use_rb;
        rd_addr_s[2] = a_q.rc;  rd_use_s[2] = a_q.use_rc;
        rd_addr_s[3] = b_q.ra;  rd_use_s[3] = b_q.use_ra;
        rd_addr_s[4] = b_q.rb;  rd_use_s[4] = b_q.use_rb;
        rd_addr_s[5] = b_q.rc;  rd_use_s[5] = b_q.use_rc;
    end

    // Hazard evaluation and issue decision for the held content.
    always_comb begin
        a_rdy_s   = &rd_rdy_s[2:0];
        b_rdy_s   = &rd_rdy_s[5:3];
        // B may join A only on the other pipe, with no RAW on A.rt and no WAW.
        pair_ok_s = (a_q.pipe != b_q.pipe) && b_rdy_s &&
                    !(a_q.wr_rt && src_hits(b_q, a_q.rt)) &&
                    !(a_q.wr_rt && b_q.wr_rt && (a_q.rt == b_q.rt));

        a_iss_s = 1'b0;
        b_iss_s = 1'b0;
        drain_s = 1'b0;   // all remaining held content leaves this cycle
        stall_d = 1'b0;
        case (state_q)
            EMPTY: begin
                drain_s = 1'b1;
            end
            FULL: begin
                a_iss_s = a_rdy_s && !flush;
                b_iss_s = a_iss_s && pair_ok_s;
                drain_s = a_rdy_s && pair_ok_s;
                stall_d = !a_rdy_s && !flush;
            end
            HALF: begin
                b_iss_s = b_rdy_s && !flush;
                drain_s = b_rdy_s;
                stall_d = !b_rdy_s && !flush;
            end
            default: begin
                drain_s = 1'b1;
            end
        endcase

        in_ready = !flush && drain_s;
        accept_s = in_valid && in_ready;
    end

    // Holding state and pair registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept_s) begin
            state_d = FULL;
            a_d     = in_a;
            b_d     = in_b;
        end else begin
            case (state_q)
                FULL: begin
                    if (a_iss_s && b_iss_s) begin
                        state_d = EMPTY;
                    end else if (a_iss_s) begin
                        state_d = HALF;
                    end else begin
                        state_d = FULL;
                    end
                end
                HALF: begin
                    if (b_iss_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = HALF;
                    end
                end
                EMPTY:   state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Slot steering by pipe bit; dual issue guarantees the pipes differ.
    always_comb begin
        slot_e_d = nop_slot(NOP_OPCODE_E);
        slot_o_d = nop_slot(LNOP_OPCODE_O);
        pc_o_d   = '0;
        if (a_iss_s) begin
            if (a_q.pipe) begin
                slot_o_d = to_slot(a_q);
                pc_o_d   = a_q.pc;
            end else begin
                slot_e_d = to_slot(a_q);
            end
        end else begin
            slot_e_d = slot_e_d;
        end
        if (b_iss_s) begin
            if (b_q.pipe) begin
                slot_o_d = to_slot(b_q);
                pc_o_d   = b_q.pc;
            end else begin
                slot_e_d = to_slot(b_q);
            end
        end else begin
            slot_o_d = slot_o_d;
        end
    end

    // Scoreboard updates from issuing writers.
    always_comb begin
        set_en_s[0]   = a_iss_s && a_q.wr_rt;
        set_addr_s[0] = a_q.rt;
        set_lat_s[0]  = LATW'(a_q.lat);
        set_en_s[1]   = b_iss_s && b_q.wr_rt;
        set_addr_s[1] = b_q.rt;
        set_lat_s[1]  = LATW'(b_q.lat);
    end

    // State, held pair and registered reg_fetch outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            a_q      <= '0;
            b_q      <= '0;
            slot_e_q <= nop_slot(NOP_OPCODE_E);
            slot_o_q <= nop_slot(LNOP_OPCODE_O);
            pc_o_q   <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            slot_e_q <= slot_e_d;
            slot_o_q <= slot_o_d;
            pc_o_q   <= pc_o_d;
            stall_q  <= stall_d;
        end
    end

    assign op_code_e    = slot_e_q.op;
    assign pres_addr_e1 = slot_e_q.ra;
    assign pres_addr_e2 = slot_e_q.rb;
    assign pres_addr_e3 = slot_e_q.rc;
    assign pres_dest_e  = slot_e_q.rt;
    assign imm_e        = slot_e_q.imm;
    assign op_code_o    = slot_o_q.op;
    assign pres_addr_o1 = slot_o_q.ra;
    assign pres_addr_o2 = slot_o_q.rb;
    assign pres_addr_o3 = slot_o_q.rc;
    assign pres_dest_o  = slot_o_q.rt;
    assign imm_o        = slot_o_q.imm;
    assign pc_o         = pc_o_q;
    assign stall        = stall_q;

endmodule

// File: tb/tb_dual_issue.sv
// Directed self-checking bench for dual_issue: reset state, dual issue,
// same-pipe split, scoreboard RAW stall, intra-pair RAW, flush while
// stalled, and reset while half-held.
module tb_dual_issue;
    import spu_issue_pkg::*;

    localparam logic [10:0] EXP_NOP_E  = 11'b01000000001;
    localparam logic [10:0] EXP_LNOP_O = 11'b00000000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    dec_inst_t   in_a;
    dec_inst_t   in_b;
    logic        flush;
    logic [0:10] op_code_e, op_code_o;
    logic [0:6]  pres_addr_e1, pres_addr_e2, pres_addr_e3;
    logic [0:6]  pres_addr_o1, pres_addr_o2, pres_addr_o3;
    logic [0:6]  pres_dest_e, pres_dest_o;
    logic [0:17] imm_e, imm_o;
    logic [0:14] pc_o;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    dec_inst_t a1, b1, a2, b2, a3, b3, a4, b4, a5, b5, a6, b6, a7, b7, a8, b8;

    dual_issue #(.NREG(128), .LATW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .flush        (flush),
        .op_code_e    (op_code_e),
        .op_code_o    (op_code_o),
        .pres_addr_e1 (pres_addr_e1),
        .pres_addr_e2 (pres_addr_e2),
        .pres_addr_e3 (pres_addr_e3),
        .pres_addr_o1 (pres_addr_o1),
        .pres_addr_o2 (pres_addr_o2),
        .pres_addr_o3 (pres_addr_o3),
        .pres_dest_e  (pres_dest_e),
        .pres_dest_o  (pres_dest_o),
        .imm_e        (imm_e),
        .imm_o        (imm_o),
        .pc_o         (pc_o),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // u = {use_ra, use_rb, use_rc}
    function automatic dec_inst_t mk(input logic [10:0] op, input logic pipe,
                                     input logic [6:0] rt, input logic [6:0] ra,
                                     input logic [6:0] rb, input logic [6:0] rc,
                                     input logic [2:0] u, input logic wr,
                                     input logic [2:0] lat, input logic [17:0] imm,
                                     input logic [14:0] pc);
        dec_inst_t d;
        d.op = op;  d.pipe = pipe; d.rt = rt; d.ra = ra; d.rb = rb; d.rc = rc;
        d.use_ra = u[2]; d.use_rb = u[1]; d.use_rc = u[0];
        d.wr_rt = wr; d.lat = lat; d.imm = imm; d.pc = pc;
        return d;
    endfunction

    initial begin
        a1 = mk(11'h0C1, 1'b0, 7'd3,  7'd1,  7'd2,  7'd0, 3'b110, 1'b1, 3'd2, 18'h00123, 15'h0010);
        b1 = mk(11'h1B0, 1'b1, 7'd4,  7'd8,  7'd0,  7'd0, 3'b100, 1'b1, 3'd4, 18'h00003, 15'h0011);
        a2 = mk(11'h0A0, 1'b0, 7'd5,  7'd0,  7'd0,  7'd0, 3'b000, 1'b1, 3'd0, 18'h00005, 15'h0020);
        b2 = mk(11'h0A1, 1'b0, 7'd6,  7'd0,  7'd0,  7'd0, 3'b000, 1'b1, 3'd0, 18'h00006, 15'h0021);
        a3 = mk(11'h0C2, 1'b0, 7'd5,  7'd0,  7'd0,  7'd0, 3'b000, 1'b1, 3'd6, 18'h00000, 15'h0030);
        b3 = mk(11'h1B1, 1'b1, 7'd12, 7'd0,  7'd0,  7'd0, 3'b000, 1'b0, 3'd0, 18'h00000, 15'h0031);
        a4 = mk(11'h0C3, 1'b0, 7'd9,  7'd5,  7'd0,  7'd0, 3'b100, 1'b1, 3'd0, 18'h00044, 15'h0040);
        b4 = mk(11'h1B2, 1'b1, 7'd13, 7'd0,  7'd0,  7'd0, 3'b000, 1'b0, 3'd0, 18'h00000, 15'h0041);
        a5 = mk(11'h1C0, 1'b1, 7'd10, 7'd0,  7'd0,  7'd0, 3'b000, 1'b1, 3'd4, 18'h00007, 15'h0050);
        b5 = mk(11'h0D0, 1'b0, 7'd11, 7'd0,  7'd10, 7'd0, 3'b010, 1'b1, 3'd0, 18'h00008, 15'h0051);
        a6 = mk(11'h0E0, 1'b0, 7'd20, 7'd0,  7'd0,  7'd0, 3'b000, 1'b1, 3'd7, 18'h00000, 15'h0060);
        b6 = mk(11'h1E0, 1'b1, 7'd21, 7'd0,  7'd0,  7'd0, 3'b000, 1'b0, 3'd0, 18'h00000, 15'h0061);
        a7 = mk(11'h0E1, 1'b0, 7'd22, 7'd20, 7'd0,  7'd0, 3'b100, 1'b1, 3'd0, 18'h00000, 15'h0070);
        b7 = mk(11'h1E1, 1'b1, 7'd23, 7'd0,  7'd0,  7'd0, 3'b000, 1'b0, 3'd0, 18'h00000, 15'h0071);
        a8 = mk(11'h1F0, 1'b1, 7'd7,  7'd0,  7'd0,  7'd0, 3'b000, 1'b1, 3'd3, 18'h00000, 15'h0080);
        b8 = mk(11'h0F0, 1'b0, 7'd14, 7'd7,  7'd0,  7'd0, 3'b100, 1'b1, 3'd0, 18'h00000, 15'h0081);

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_a = '0; in_b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_op_e",   op_code_e, EXP_NOP_E);
        chk("rst_op_o",   op_code_o, EXP_LNOP_O);
        chk("rst_stall",  stall, 1'b0);
        chk("rst_ready",  in_ready, 1'b1);
        chk("rst_addr_e1", pres_addr_e1, 7'd0);
        chk("rst_pc_o",   pc_o, 15'd0);

        // Independent even/odd pair: dual issue.
        in_valid = 1'b1; in_a = a1; in_b = b1;
        tick();
        in_valid = 1'b0;
        chk("t1_ready_held", in_ready, 1'b1);
        tick();
        chk("t1_op_e",   op_code_e, 11'h0C1);
        chk("t1_ae1",    pres_addr_e1, 7'd1);
        chk("t1_ae2",    pres_addr_e2, 7'd2);
        chk("t1_dest_e", pres_dest_e, 7'd3);
        chk("t1_imm_e",  imm_e, 18'h00123);
        chk("t1_op_o",   op_code_o, 11'h1B0);
        chk("t1_ao1",    pres_addr_o1, 7'd8);
        chk("t1_dest_o", pres_dest_o, 7'd4);
        chk("t1_pc_o",   pc_o, 15'h0011);
        chk("t1_stall",  stall, 1'b0);
        chk("t1_sb3",    dut.u_sb.sb_q[3], 3'd2);

        // Both even: split over two cycles.
        in_valid = 1'b1; in_a = a2; in_b = b2;
        tick();
        in_valid = 1'b0;
        chk("t2_ready_low", in_ready, 1'b0);
        tick();
        chk("t2_c1_op_e",  op_code_e, 11'h0A0);
        chk("t2_c1_dest_e", pres_dest_e, 7'd5);
        chk("t2_c1_op_o",  op_code_o, EXP_LNOP_O);
        chk("t2_c1_stall", stall, 1'b0);
        chk("t2_c1_ready", in_ready, 1'b1);
        tick();
        chk("t2_c2_op_e",  op_code_e, 11'h0A1);
        chk("t2_c2_imm_e", imm_e, 18'h00006);
        chk("t2_c2_op_o",  op_code_o, EXP_LNOP_O);

        // Producer of r5 lat 6, next pair reads r5: six stall cycles.
        in_valid = 1'b1; in_a = a3; in_b = b3;
        tick();
        in_a = a4; in_b = b4;
        chk("t3_ready_b2b", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t3_sb5_init", dut.u_sb.sb_q[5], 3'd6);
        chk("t3_p1_op_e",  op_code_e, 11'h0C2);
        chk("t3_p1_pc_o",  pc_o, 15'h0031);
        chk("t3_blk_ready", in_ready, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("t3_stall_%0d", k), stall, 1'b1);
            chk($sformatf("t3_sb5_%0d", k), dut.u_sb.sb_q[5], 32'(6 - k));
            chk($sformatf("t3_nop_%0d", k), op_code_e, EXP_NOP_E);
        end
        tick();
        chk("t3_rel_stall", stall, 1'b0);
        chk("t3_rel_op_e",  op_code_e, 11'h0C3);
        chk("t3_rel_ae1",   pres_addr_e1, 7'd5);
        chk("t3_rel_op_o",  op_code_o, 11'h1B2);
        chk("t3_rel_pc_o",  pc_o, 15'h0041);

        // Intra-pair RAW: A odd writes r10 lat 4, B even reads r10.
        in_valid = 1'b1; in_a = a5; in_b = b5;
        tick();
        in_valid = 1'b0;
        chk("t4_ready_low", in_ready, 1'b0);
        tick();
        chk("t4_a_op_o",  op_code_o, 11'h1C0);
        chk("t4_a_pc_o",  pc_o, 15'h0050);
        chk("t4_a_op_e",  op_code_e, EXP_NOP_E);
        chk("t4_a_stall", stall, 1'b0);
        chk("t4_sb10",    dut.u_sb.sb_q[10], 3'd4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("t4_stall_%0d", k), stall, 1'b1);
            chk($sformatf("t4_nop_%0d", k), op_code_e, EXP_NOP_E);
        end
        tick();
        chk("t4_b_stall",  stall, 1'b0);
        chk("t4_b_op_e",   op_code_e, 11'h0D0);
        chk("t4_b_ae2",    pres_addr_e2, 7'd10);
        chk("t4_b_dest_e", pres_dest_e, 7'd11);
        chk("t4_b_op_o",   op_code_o, EXP_LNOP_O);

        // Flush while FULL and stalled.
        in_valid = 1'b1; in_a = a6; in_b = b6;
        tick();
        in_a = a7; in_b = b7;
        tick();
        in_valid = 1'b0;
        chk("t5_sb20_7", dut.u_sb.sb_q[20], 3'd7);
        tick();
        chk("t5_stall_a", stall, 1'b1);
        tick();
        chk("t5_stall_b", stall, 1'b1);
        flush = 1'b1;
        #1;
        chk("t5_flush_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        chk("t5_op_e",  op_code_e, EXP_NOP_E);
        chk("t5_op_o",  op_code_o, EXP_LNOP_O);
        chk("t5_pc_o",  pc_o, 15'd0);
        chk("t5_sb20",  dut.u_sb.sb_q[20], 3'd4);
        chk("t5_ready", in_ready, 1'b1);
        tick();
        chk("t5_discard_op_e", op_code_e, EXP_NOP_E);
        chk("t5_discard_stall", stall, 1'b0);
        chk("t5_sb20_cnt", dut.u_sb.sb_q[20], 3'd3);

        // Reset while HALF with sb[7] = 3.
        in_valid = 1'b1; in_a = a8; in_b = b8;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t6_sb7",   dut.u_sb.sb_q[7], 3'd3);
        chk("t6_op_o",  op_code_o, 11'h1F0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_ready", in_ready, 1'b1);
        chk("t6_sb7_clr", dut.u_sb.sb_q[7], 3'd0);
        chk("t6_sb20_clr", dut.u_sb.sb_q[20], 3'd0);
        chk("t6_op_e",  op_code_e, EXP_NOP_E);
        chk("t6_op_o_nop", op_code_o, EXP_LNOP_O);
        chk("t6_pc_o",  pc_o, 15'd0);
        chk("t6_dest_o", pres_dest_o, 7'd0);
        chk("t6_stall", stall, 1'b0);
        tick();
        chk("t6_after_op_e", op_code_e, EXP_NOP_E);
        chk("t6_after_stall", stall, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
